// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Bus between the execute stage's load/store initiator and the data memory
// responder.
//   read  : mem_readEn / mem_readAddr -> mem_readFin / mem_radData
//   write : mem_writeEn / mem_writeAddr / mem_writeData (single cycle)
//   load  : load_en / load_addr / load_data (preload port, word indexed)
//   status: busy (responder not idle)
// Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int XLEN           = 32,
  parameter int READ_ADDR_SIZE = 32,
  parameter int MEM_DEPTH_LOG2 = 10
);
  logic                      mem_readEn;
  logic [READ_ADDR_SIZE-1:0] mem_readAddr;
  logic                      mem_readFin;
  logic [XLEN-1:0]           mem_radData;
  logic                      mem_writeEn;
  logic [READ_ADDR_SIZE-1:0] mem_writeAddr;
  logic [XLEN-1:0]           mem_writeData;
  logic                      load_en;
  logic [MEM_DEPTH_LOG2-1:0] load_addr;
  logic [XLEN-1:0]           load_data;
  logic                      busy;

  modport master (
    output mem_readEn, mem_readAddr, mem_writeEn, mem_writeAddr, mem_writeData,
           load_en, load_addr, load_data,
    input  mem_readFin, mem_radData, busy
  );

  modport slave (
    input  mem_readEn, mem_readAddr, mem_writeEn, mem_writeAddr, mem_writeData,
           load_en, load_addr, load_data,
    output mem_readFin, mem_radData, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the execute stage's load/store interface.
// Serves level-held read requests with READ_LATENCY cycles of latency and a
// one-cycle completion pulse, commits single-cycle word writes in any state,
// and offers a preload port that takes priority over bus writes.
// Ports:
//   clk   : clock, all state changes on posedge
//   rst_n : asynchronous active-low reset (array contents are not reset)
//   bus   : data_mem_responder_if.slave (read / write / preload / busy)
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int XLEN           = 32,
  parameter int READ_ADDR_SIZE = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int READ_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter load value on acceptance; unused when READ_LATENCY is 1.
  localparam logic [3:0] LAT_RELOAD = 4'(READ_LATENCY - 2);

  logic [XLEN-1:0]           r_mem [DEPTH];
  logic [1:0]                r_state;
  logic [3:0]                r_cnt;
  logic [MEM_DEPTH_LOG2-1:0] r_idx;
  logic                      r_fin;
  logic [XLEN-1:0]           r_rdata;

  logic [1:0]                w_state_nxt;
  logic [3:0]                w_cnt_nxt;
  logic [MEM_DEPTH_LOG2-1:0] w_idx_nxt;
  logic                      w_enter_done;
  logic [MEM_DEPTH_LOG2-1:0] w_rd_idx;
  logic [MEM_DEPTH_LOG2-1:0] w_rd_addr_idx;
  logic [MEM_DEPTH_LOG2-1:0] w_wr_addr_idx;
  logic                      w_wr_en;
  logic [MEM_DEPTH_LOG2-1:0] w_wr_idx;
  logic [XLEN-1:0]           w_wr_data;
  logic [XLEN-1:0]           w_rd_word;

  // Byte-offset and upper address bits are deliberately dropped: accesses
  // are full-word and wrap modulo the array size.
  logic [2*(READ_ADDR_SIZE-MEM_DEPTH_LOG2)-1:0] w_unused_addr_bits;

  assign w_rd_addr_idx = bus.mem_readAddr[MEM_DEPTH_LOG2+1:2];
  assign w_wr_addr_idx = bus.mem_writeAddr[MEM_DEPTH_LOG2+1:2];
  assign w_unused_addr_bits = {bus.mem_readAddr[READ_ADDR_SIZE-1:MEM_DEPTH_LOG2+2],
                               bus.mem_readAddr[1:0],
                               bus.mem_writeAddr[READ_ADDR_SIZE-1:MEM_DEPTH_LOG2+2],
                               bus.mem_writeAddr[1:0]};

  // Single array write port: preload wins over a bus write in the same cycle.
  assign w_wr_en   = bus.load_en | bus.mem_writeEn;
  assign w_wr_idx  = bus.load_en ? bus.load_addr : w_wr_addr_idx;
  assign w_wr_data = bus.load_en ? bus.load_data : bus.mem_writeData;

  // Next-state logic for the read FSM; also selects which index is read on
  // the edge entering DONE (the live address when latency is 1).
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_enter_done = 1'b0;
    w_rd_idx     = r_idx;
    case (r_state)
      S_IDLE: begin
        w_rd_idx = w_rd_addr_idx;
        if (bus.mem_readEn) begin
          w_idx_nxt = w_rd_addr_idx;
          if (READ_LATENCY == 1) begin
            w_state_nxt  = S_DONE;
            w_enter_done = 1'b1;
          end else begin
            w_cnt_nxt   = LAT_RELOAD;
            w_state_nxt = S_BUSY;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!bus.mem_readEn) begin
          // Initiator withdrew the request: abort silently.
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt  = S_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read word with write-to-read bypass for a same-edge write to that index.
  always_comb begin
    if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
      w_rd_word = w_wr_data;
    end else begin
      w_rd_word = r_mem[w_rd_idx];
    end
  end

  // FSM, counter, latched index and registered read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_fin   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_fin   <= w_enter_done;
      if (w_enter_done) begin
        r_rdata <= w_rd_word;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // Data array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  assign bus.mem_readFin = r_fin;
  assign bus.mem_radData = r_rdata;
  assign bus.busy        = (r_state != S_IDLE);

endmodule
